// File: rtl/wbs_pwm_ctrl.sv
// Wishbone B4 pipelined slave owning the shared 8-bit PWM counter, prescaler and
// per-channel duty shadows; duty updates reach the channels only at period wrap.
module wbs_pwm_ctrl #(
   parameter int unsigned CHANNELS = 4
) (
   input  logic                    wbs_clk_i,
   input  logic                    wbs_rst_ni,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_adr_i,
   input  logic [7:0]              wbs_dat_i,
   output logic [7:0]              wbs_dat_o,
   output logic                    wbs_ack_o,
   output logic                    wbs_stall_o,
   output logic [7:0]              pwm_counter,
   output logic [CHANNELS-1:0]     ch_stb_o,
   output logic [8*CHANNELS-1:0]   ch_dat_o
);

   logic                en;
   logic [7:0]          prescale;
   logic [7:0]          prescale_cnt;
   logic [7:0]          shadow [CHANNELS];
   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] duty_wr;
   logic [CHANNELS-1:0] commit_mask;
   logic [7:0]          status;
   logic [7:0]          rdata;
   logic                wr;
   logic                tick;
   logic                commit;

   assign wbs_stall_o = 1'b0;
   assign wr          = wbs_stb_i && wbs_we_i;
   assign tick        = en && (prescale_cnt >= prescale);
   // With EN low every cycle is a commit cycle, so pending duties load at once.
   assign commit      = (tick && (pwm_counter == 8'hFF)) || !en;
   assign commit_mask = commit ? pending : '0;
   assign ch_stb_o    = commit_mask;

   always_comb begin
      duty_wr = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (wr && (wbs_adr_i == 4'(4 + i))) begin
            duty_wr[i] = 1'b1;
         end
      end
   end

   always_comb begin
      status = '0;
      status[CHANNELS-1:0] = pending;
   end

   always_comb begin
      rdata = '0;
      case (wbs_adr_i)
         4'd0:    rdata = {7'd0, en};
         4'd1:    rdata = prescale;
         4'd2:    rdata = status;
         default: rdata = '0;
      endcase
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (wbs_adr_i == 4'(4 + i)) begin
            rdata = shadow[i];
         end
      end
   end

   always_comb begin
      ch_dat_o = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         ch_dat_o[8*i +: 8] = shadow[i];
      end
   end

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
      if (!wbs_rst_ni) begin
         en        <= 1'b0;
         prescale  <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         wbs_ack_o <= wbs_stb_i;
         wbs_dat_o <= (wbs_stb_i && !wbs_we_i) ? rdata : '0;
         if (wr && (wbs_adr_i == 4'd0)) begin
            en <= wbs_dat_i[0];
         end
         if (wr && (wbs_adr_i == 4'd1)) begin
            prescale <= wbs_dat_i;
         end
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (duty_wr[i]) begin
               shadow[i] <= wbs_dat_i;
            end
         end
      end
   end

   // A write landing in the commit cycle re-arms its channel: set wins over clear.
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
      if (!wbs_rst_ni) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~commit_mask) | duty_wr;
      end
   end

   always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
      if (!wbs_rst_ni) begin
         prescale_cnt <= '0;
         pwm_counter  <= '0;
      end else if (!en) begin
         prescale_cnt <= '0;
         pwm_counter  <= '0;
      end else if (tick) begin
         prescale_cnt <= '0;
         pwm_counter  <= pwm_counter + 8'd1;
      end else begin
         prescale_cnt <= prescale_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_wbs_pwm_ctrl.sv
// Directed bench for wbs_pwm_ctrl: bus handshake, prescaled counter and
// period-aligned duty commits, with hand-computed expectations.
module tb_wbs_pwm_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stb;
   logic        we;
   logic [3:0]  adr;
   logic [7:0]  wdat;
   logic [7:0]  rdat;
   logic        ack;
   logic        stall;
   logic [7:0]  counter;
   logic [3:0]  ch_stb;
   logic [31:0] ch_dat;

   int unsigned n_checks;
   int unsigned n_errors;

   wbs_pwm_ctrl #(.CHANNELS(4)) dut (
      .wbs_clk_i   (clk),
      .wbs_rst_ni  (rst_n),
      .wbs_stb_i   (stb),
      .wbs_we_i    (we),
      .wbs_adr_i   (adr),
      .wbs_dat_i   (wdat),
      .wbs_dat_o   (rdat),
      .wbs_ack_o   (ack),
      .wbs_stall_o (stall),
      .pwm_counter (counter),
      .ch_stb_o    (ch_stb),
      .ch_dat_o    (ch_dat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one strobe at the current negedge, check the ack cycle, release.
   task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input string tag);
      stb  = 1'b1;
      we   = w;
      adr  = a;
      wdat = d;
      @(negedge clk);
      check({tag, "_ack"}, 32'(ack), 32'd1);
      check({tag, "_dat"}, 32'(rdat), w ? 32'd0 : 32'(exp_rd));
      stb  = 1'b0;
      we   = 1'b0;
   endtask

   // Disable, set prescaler, re-enable: counter and prescale count start at 0.
   task automatic restart(input logic [7:0] pre);
      bus(1'b1, 4'd0, 8'h00, 8'h00, "rs_ctrl0");
      bus(1'b1, 4'd1, pre,   8'h00, "rs_pre");
      bus(1'b1, 4'd0, 8'h01, 8'h00, "rs_ctrl1");
   endtask

   logic       b2b_we  [10];
   logic [3:0] b2b_adr [10];
   logic [7:0] b2b_dat [10];
   logic [7:0] b2b_exp [10];
   logic       seen_early;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;

      repeat (3) @(negedge clk);
      check("rst_counter", 32'(counter), 32'd0);
      check("rst_ack",     32'(ack),     32'd0);
      check("rst_chstb",   32'(ch_stb),  32'd0);
      check("rst_chdat",   ch_dat,       32'd0);
      check("rst_rdat",    32'(rdat),    32'd0);
      check("stall",       32'(stall),   32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_counter", 32'(counter), 32'd0);
      check("idle_ack",     32'(ack),     32'd0);
      bus(1'b0, 4'd2, 8'h00, 8'h00, "status0");
      @(negedge clk);
      check("ack_single", 32'(ack), 32'd0);

      // PRESCALE=0: counter steps every cycle and wraps.
      restart(8'd0);
      check("cnt_start", 32'(counter), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("cnt_step", 32'(counter), 32'(k));
      end
      repeat (251) @(negedge clk);
      check("cnt_254", 32'(counter), 32'd254);
      @(negedge clk);
      check("cnt_255", 32'(counter), 32'd255);
      @(negedge clk);
      check("cnt_wrap", 32'(counter), 32'd0);

      // PRESCALE=3: one step per 4 cycles.
      restart(8'd3);
      repeat (3) @(negedge clk);
      check("pre3_hold", 32'(counter), 32'd0);
      @(negedge clk);
      check("pre3_one", 32'(counter), 32'd1);
      repeat (4) @(negedge clk);
      check("pre3_two", 32'(counter), 32'd2);

      // DUTY[2]=0x80 written at counter 10, commits at 255->0.
      restart(8'd0);
      repeat (10) @(negedge clk);
      bus(1'b1, 4'd6, 8'h80, 8'h00, "duty2");
      bus(1'b0, 4'd2, 8'h00, 8'h04, "status_pend2");
      seen_early = 1'b0;
      repeat (242) begin
         @(negedge clk);
         if (ch_stb != 4'd0) seen_early = 1'b1;
      end
      check("no_early_stb", 32'(seen_early), 32'd0);
      @(negedge clk);
      check("c2_counter", 32'(counter), 32'd255);
      check("c2_stb",     32'(ch_stb),  32'h4);
      check("c2_dat",     32'(ch_dat[23:16]), 32'h80);
      @(negedge clk);
      check("c2_counter0", 32'(counter), 32'd0);
      check("c2_stb_off",  32'(ch_stb),  32'h0);
      bus(1'b0, 4'd2, 8'h00, 8'h00, "status_clr2");

      // EN=0: commit in the cycle after the write.
      bus(1'b1, 4'd0, 8'h00, 8'h00, "dis");
      @(negedge clk);
      bus(1'b1, 4'd4, 8'h40, 8'h00, "duty0");
      check("d0_stb",     32'(ch_stb), 32'h1);
      check("d0_dat",     32'(ch_dat[7:0]), 32'h40);
      check("d0_counter", 32'(counter), 32'd0);
      @(negedge clk);
      check("d0_stb_off", 32'(ch_stb), 32'h0);
      check("d0_counter2", 32'(counter), 32'd0);

      // Write landing exactly in the commit cycle.
      restart(8'd0);
      bus(1'b1, 4'd5, 8'h10, 8'h00, "duty1a");
      repeat (254) @(negedge clk);
      check("c1a_counter", 32'(counter), 32'd255);
      check("c1a_stb",     32'(ch_stb),  32'h2);
      check("c1a_dat",     32'(ch_dat[15:8]), 32'h10);
      bus(1'b1, 4'd5, 8'h20, 8'h00, "duty1b");
      check("c1b_shadow", 32'(ch_dat[15:8]), 32'h20);
      bus(1'b0, 4'd2, 8'h00, 8'h02, "status_keep1");
      repeat (254) @(negedge clk);
      check("c1b_counter", 32'(counter), 32'd255);
      check("c1b_stb",     32'(ch_stb),  32'h2);
      check("c1b_dat",     32'(ch_dat[15:8]), 32'h20);
      @(negedge clk);
      check("c1b_stb_off", 32'(ch_stb), 32'h0);
      bus(1'b0, 4'd2, 8'h00, 8'h00, "status_clr1");

      // Back-to-back strobes, one ack each.
      b2b_we  = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
      b2b_adr = '{4'd0,  4'd1,  4'd4,  4'd15, 4'd0,  4'd1,  4'd4,  4'd15, 4'd1,  4'd1};
      b2b_dat = '{8'h01, 8'h05, 8'hAA, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00};
      b2b_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'hAA, 8'h00, 8'h00, 8'h09};
      for (int k = 0; k < 10; k++) begin
         stb  = 1'b1;
         we   = b2b_we[k];
         adr  = b2b_adr[k];
         wdat = b2b_dat[k];
         @(negedge clk);
         check("b2b_ack", 32'(ack), 32'd1);
         check("b2b_dat", 32'(rdat), 32'(b2b_exp[k]));
      end
      stb = 1'b0;
      we  = 1'b0;
      @(negedge clk);
      check("b2b_ack_end", 32'(ack), 32'd0);

      // Asynchronous reset while an ack is on the bus.
      stb = 1'b1;
      adr = 4'd1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      check("pre_rst_ack", 32'(ack),  32'd1);
      check("pre_rst_dat", 32'(rdat), 32'h09);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_ack",     32'(ack),     32'd0);
      check("arst_rdat",    32'(rdat),    32'd0);
      check("arst_counter", 32'(counter), 32'd0);
      check("arst_chstb",   32'(ch_stb),  32'd0);
      check("arst_chdat",   ch_dat,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus(1'b0, 4'd0, 8'h00, 8'h00, "post_ctrl");
      bus(1'b0, 4'd1, 8'h00, 8'h00, "post_pre");
      bus(1'b0, 4'd2, 8'h00, 8'h00, "post_status");
      bus(1'b0, 4'd4, 8'h00, 8'h00, "post_duty0");
      check("post_counter", 32'(counter), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wbs_pwm_ctrl.md
Name: wbs_pwm_ctrl

Overview:
Wishbone B4 pipelined slave that owns the shared 8-bit PWM counter and sequences duty-cycle updates to CHANNELS wbs_pwm_channel-style instances.
- Holds a software-visible shadow duty register per channel.
- Commits new duties to the channels only at the period boundary, so a PWM period is never cut short or glitched.
- Provides a programmable prescaler and a global enable.

Parameters:
CHANNELS, 4, number of PWM channels driven; legal range 1..8.

Ports:
wbs_clk_i  input  1  system clock
wbs_rst_ni  input  1  asynchronous active-low reset
wbs_stb_i  input  1  Wishbone strobe (cyc implied)
wbs_we_i  input  1  write enable
wbs_adr_i  input  4  register address
wbs_dat_i  input  8  write data
wbs_dat_o  output  8  read data, valid with ack
wbs_ack_o  output  1  acknowledge
wbs_stall_o  output  1  stall, tied 0
pwm_counter  output  8  shared free-running PWM counter to all channels
ch_stb_o  output  CHANNELS  per-channel duty load strobe
ch_dat_o  output  8*CHANNELS  per-channel duty value; channel i uses bits [8i+7:8i]

Behaviour:
Reset (asynchronous, wbs_rst_ni=0):
- All registers clear: CTRL=0, PRESCALE=0, shadows=0, pending=0, prescale count=0, pwm_counter=0.
- Outputs: wbs_ack_o=0, wbs_dat_o=0, ch_stb_o=0, ch_dat_o=0.
- Reset may assert at any cycle; no partial commit survives it.

Register map (8-bit):
- 0 CTRL: bit0 EN, other bits read 0.
- 1 PRESCALE: tick divisor minus 1.
- 2 STATUS: read-only pending mask, bit i = channel i has an uncommitted duty.
- 3: reserved, reads 0.
- 4..4+CHANNELS-1: DUTY[i] shadow.
- Writes to read-only, reserved or out-of-range addresses are ignored; reads of out-of-range addresses return 0.

Bus handshake:
- Every cycle with wbs_stb_i=1 is a request; no stalls.
- wbs_ack_o=1 exactly 1 cycle after each strobe, back-to-back supported.
- wbs_dat_o carries the read value in the ack cycle; 0 for writes.
- Register write takes effect at the strobe clock edge.
- A read in the cycle after a write to the same register returns the new value.

Prescaler / counter:
- Prescale count increments each cycle while EN=1.
- tick = EN && (prescale count >= PRESCALE); on tick, prescale count returns to 0.
- Using >= means a lowered PRESCALE mid-count ticks on the next cycle.
- PRESCALE=0: tick every cycle.
- On tick, pwm_counter increments modulo 256.
- EN=0: prescale count and pwm_counter are held at 0.
- Clearing EN resets both to 0 on the next edge.
- Setting EN restarts from count 0.

Commit sequencing:
- A DUTY[i] write sets pending[i], including writes of an unchanged value.
- Commit condition: (tick && pwm_counter==255) || EN=0.
- In the commit cycle, ch_stb_o[i]=pending[i] for 1 cycle, ch_dat_o slice i = shadow[i], and pending is cleared.
- With EN=1, the channel load therefore coincides with the edge where pwm_counter wraps to 0.
- All pending channels commit in the same cycle.
- ch_dat_o continuously reflects shadows; only the strobe is gated.
- Simultaneous DUTY[i] write and commit: the old shadow value commits, the new value lands in the shadow, and pending[i] stays 1 (set wins over clear).

Test Plan:
- Reset then idle -> pwm_counter=0, ack=0, all ch_stb_o=0; read STATUS -> 0x00 with ack exactly 1 cycle after stb.
- EN=1, PRESCALE=0 -> pwm_counter increments every cycle, 255 wraps to 0. PRESCALE=3 -> increments every 4th cycle.
- EN=1, write DUTY[2]=0x80 while pwm_counter=10 -> STATUS=0x04; ch_stb_o[2] pulses for 1 cycle only when pwm_counter goes 255->0, with ch_dat_o[23:16]=0x80; STATUS then reads 0x00.
- EN=0, write DUTY[0]=0x40 -> ch_stb_o[0] pulses in the following cycle; pwm_counter stays 0.
- Write DUTY[1]=0x10 early, then DUTY[1]=0x20 exactly in the commit cycle -> channel receives 0x10 at this wrap; pending[1] remains 1; 0x20 commits at the next wrap.
- Back-to-back writes/reads on consecutive cycles at addresses 0,1,4,15 -> one ack per strobe, readback correct, address 15 reads 0; assert wbs_rst_ni low mid-period -> all state and outputs clear immediately.
